// File: rtl/wb_ctrl_pkg.sv
// Shared widths, source codes and helpers for the writeback controller slice.
package wb_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;
  localparam int REG_NUM    = 32;
  localparam int STARVE_W   = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      reg_t;

  localparam reg_t ZERO_WORD = '0;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_LSU  = 2'd2,
    WB_SRC_MDU  = 2'd3
  } wb_src_e;

  function automatic logic [REG_NUM-1:0] reg_onehot(input reg_addr_t a);
    reg_onehot    = '0;
    reg_onehot[a] = 1'b1;
  endfunction
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination vector for issue hazard checks; set on issue, cleared on LSU/MDU writeback.
module wb_scoreboard
  import wb_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               set_i,
  input  reg_addr_t          set_addr_i,
  input  logic               clr_i,
  input  reg_addr_t          clr_addr_i,
  output logic [REG_NUM-1:0] busy_o
);
  logic [REG_NUM-1:0] set_mask;
  logic [REG_NUM-1:0] clr_mask;

  // x0 is never tracked; set is applied after clear so it wins on a collision
  assign set_mask = (set_i && set_addr_i != '0) ? reg_onehot(set_addr_i) : '0;
  assign clr_mask = clr_i ? reg_onehot(clr_addr_i) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_o <= '0;
    else     busy_o <= (busy_o & ~clr_mask) | set_mask;
  end
endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: arbitrates ALU/LSU/MDU results onto the single GPR write port.
// Define WB_SCOREBOARD_EN to build the pending-destination scoreboard (busy_o).
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid_i,
  input  reg_addr_t          alu_waddr_i,
  input  reg_t               alu_wdata_i,
  input  logic               lsu_valid_i,
  output logic               lsu_ready_o,
  input  reg_addr_t          lsu_waddr_i,
  input  reg_t               lsu_wdata_i,
  input  logic               mdu_valid_i,
  output logic               mdu_ready_o,
  input  reg_addr_t          mdu_waddr_i,
  input  reg_t               mdu_wdata_i,
  input  logic               sb_set_i,
  input  reg_addr_t          sb_set_addr_i,
  output logic [REG_NUM-1:0] busy_o,
  output logic               wb_we_o,
  output reg_addr_t          wb_waddr_o,
  output reg_t               wb_wdata_o
);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;
  wb_src_e             lm_win;
  wb_src_e             src_win;
  reg_addr_t           win_waddr;
  reg_t                win_wdata;
  logic                win_we;
  logic                we_p1;
  reg_addr_t           waddr_p1;
  reg_t                wdata_p1;

  // Stage 0: pick the winner; LSU/MDU only compete when the ALU is idle
  always_comb begin
    lm_win = WB_SRC_NONE;
    if (starve_cnt == STARVE_LIM) begin
      if (mdu_valid_i)      lm_win = WB_SRC_MDU;
      else if (lsu_valid_i) lm_win = WB_SRC_LSU;
    end else begin
      if (lsu_valid_i)      lm_win = WB_SRC_LSU;
      else if (mdu_valid_i) lm_win = WB_SRC_MDU;
    end
    src_win   = alu_valid_i ? WB_SRC_ALU : lm_win;
    win_waddr = '0;
    win_wdata = ZERO_WORD;
    case (src_win)
      WB_SRC_ALU: begin win_waddr = alu_waddr_i; win_wdata = alu_wdata_i; end
      WB_SRC_LSU: begin win_waddr = lsu_waddr_i; win_wdata = lsu_wdata_i; end
      WB_SRC_MDU: begin win_waddr = mdu_waddr_i; win_wdata = mdu_wdata_i; end
      default:    ;
    endcase
    win_we = (src_win != WB_SRC_NONE) && (win_waddr != '0);
  end

  assign lsu_ready_o = !alu_valid_i && (lm_win == WB_SRC_LSU);
  assign mdu_ready_o = !alu_valid_i && (lm_win == WB_SRC_MDU);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          starve_cnt <= '0;
    else if (!mdu_valid_i || src_win == WB_SRC_MDU)   starve_cnt <= '0;
    else if (starve_cnt != STARVE_LIM)                starve_cnt <= starve_cnt + STARVE_W'(1);
  end

  // Stage 1: registered write port; address/data only move on a real write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_p1    <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= ZERO_WORD;
    end else begin
      we_p1 <= win_we;
      if (win_we) begin
        waddr_p1 <= win_waddr;
        wdata_p1 <= win_wdata;
      end
    end
  end

  assign wb_we_o    = we_p1;
  assign wb_waddr_o = waddr_p1;
  assign wb_wdata_o = wdata_p1;

`ifdef WB_SCOREBOARD_EN
  logic sb_clr_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_clr_p1 <= 1'b0;
    else     sb_clr_p1 <= win_we && (src_win == WB_SRC_LSU || src_win == WB_SRC_MDU);
  end

  wb_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_i      (sb_set_i),
    .set_addr_i (sb_set_addr_i),
    .clr_i      (sb_clr_p1),
    .clr_addr_i (waddr_p1),
    .busy_o     (busy_o)
  );
`else
  logic unused_sb;
  assign unused_sb = sb_set_i ^ (^sb_set_addr_i);
  assign busy_o    = '0;
`endif
endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_wb_ctrl;
  import wb_ctrl_pkg::*;
  localparam int SMAX = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               alu_valid_i, lsu_valid_i, mdu_valid_i, sb_set_i;
  reg_addr_t          alu_waddr_i, lsu_waddr_i, mdu_waddr_i, sb_set_addr_i;
  reg_t               alu_wdata_i, lsu_wdata_i, mdu_wdata_i;
  logic               lsu_ready_o, mdu_ready_o, wb_we_o;
  reg_addr_t          wb_waddr_o;
  reg_t               wb_wdata_o;
  logic [REG_NUM-1:0] busy_o;

  wb_ctrl #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o), .mdu_waddr_i(mdu_waddr_i), .mdu_wdata_i(mdu_wdata_i),
    .sb_set_i(sb_set_i), .sb_set_addr_i(sb_set_addr_i), .busy_o(busy_o),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: expected port contents and MDU waiting time
  logic        m_we, m_from_lm;
  reg_addr_t   m_waddr;
  reg_t        m_wdata;
  logic [31:0] m_busy;
  int          m_wait;
  int          last_win;  // 0 none, 1 ALU, 2 LSU, 3 MDU

  task automatic model_reset();
    m_we = 1'b0; m_from_lm = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0; m_wait = 0;
  endtask

  // Inputs are already driven; check readies, advance one clock, check the write port.
  task automatic cycle();
    int lm, win;
    reg_addr_t wa;
    reg_t wd;
    logic [31:0] clr_m, set_m;
    #1;
    if (m_wait >= SMAX) lm = mdu_valid_i ? 3 : (lsu_valid_i ? 2 : 0);
    else                lm = lsu_valid_i ? 2 : (mdu_valid_i ? 3 : 0);
    win = alu_valid_i ? 1 : lm;
    check("lsu_ready", 32'(lsu_ready_o), 32'(!alu_valid_i && lm == 2));
    check("mdu_ready", 32'(mdu_ready_o), 32'(!alu_valid_i && lm == 3));
    wa = (win == 1) ? alu_waddr_i : (win == 2) ? lsu_waddr_i : (win == 3) ? mdu_waddr_i : '0;
    wd = (win == 1) ? alu_wdata_i : (win == 2) ? lsu_wdata_i : (win == 3) ? mdu_wdata_i : '0;
    clr_m = (m_we && m_from_lm) ? (32'd1 << m_waddr) : 32'd0;
    set_m = (sb_set_i && sb_set_addr_i != 0) ? (32'd1 << sb_set_addr_i) : 32'd0;
`ifdef WB_SCOREBOARD_EN
    m_busy = (m_busy & ~clr_m) | set_m;
`else
    m_busy = clr_m & set_m & 32'd0;
`endif
    m_we      = (win != 0) && (wa != 0);
    m_from_lm = (win >= 2);
    if (m_we) begin m_waddr = wa; m_wdata = wd; end
    if (mdu_valid_i && win != 3) m_wait = (m_wait + 1 > SMAX) ? SMAX : m_wait + 1;
    else                         m_wait = 0;
    last_win = win;
    @(posedge clk);
    @(negedge clk);
    check("wb_we", 32'(wb_we_o), 32'(m_we));
    if (m_we) begin
      check("wb_waddr", 32'(wb_waddr_o), 32'(m_waddr));
      check("wb_wdata", wb_wdata_o, m_wdata);
    end
    check("busy", busy_o, m_busy);
    if (win == 2) lsu_valid_i = 1'b0;
    if (win == 3) mdu_valid_i = 1'b0;
    alu_valid_i = 1'b0;
    sb_set_i    = 1'b0;
  endtask

  initial begin
    int acc_cyc;
    rst = 1'b1;
    alu_valid_i = 0; lsu_valid_i = 0; mdu_valid_i = 0; sb_set_i = 0;
    alu_waddr_i = '0; lsu_waddr_i = '0; mdu_waddr_i = '0; sb_set_addr_i = '0;
    alu_wdata_i = '0; lsu_wdata_i = '0; mdu_wdata_i = '0;
    model_reset();
    last_win = 0;
    #12;
    check("rst_we", 32'(wb_we_o), 32'd0);
    check("rst_waddr", 32'(wb_waddr_o), 32'd0);
    check("rst_wdata", wb_wdata_o, 32'd0);
    check("rst_busy", busy_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU only
    alu_valid_i = 1; alu_waddr_i = 5'd5; alu_wdata_i = 32'h1234;
    cycle();
    check("t1_we", 32'(wb_we_o), 32'd1);
    check("t1_waddr", 32'(wb_waddr_o), 32'd5);
    check("t1_wdata", wb_wdata_o, 32'h1234);

    // Three-way contention
    alu_valid_i = 1; alu_waddr_i = 5'd1; alu_wdata_i = 32'hA1;
    lsu_valid_i = 1; lsu_waddr_i = 5'd2; lsu_wdata_i = 32'hB2;
    mdu_valid_i = 1; mdu_waddr_i = 5'd3; mdu_wdata_i = 32'hC3;
    cycle(); check("t2_win0", 32'(last_win), 32'd1);
    cycle(); check("t2_win1", 32'(last_win), 32'd2);
    cycle(); check("t2_win2", 32'(last_win), 32'd3);
    check("t2_last_addr", 32'(wb_waddr_o), 32'd3);
    cycle();

    // MDU starvation under back-to-back loads
    acc_cyc = -1;
    mdu_valid_i = 1; mdu_waddr_i = 5'd9; mdu_wdata_i = 32'h9999;
    for (int k = 0; k < 10 && acc_cyc < 0; k++) begin
      if (!lsu_valid_i) begin
        lsu_valid_i = 1; lsu_waddr_i = reg_addr_t'(k + 10); lsu_wdata_i = 32'h5000 + k;
      end
      cycle();
      if (last_win == 3) acc_cyc = k;
    end
    check("t3_mdu_accept_cycle", 32'(acc_cyc), 32'd4);
    check("t3_mdu_written", 32'(wb_waddr_o), 32'd9);
    for (int k = 0; k < 3; k++) cycle();

    // Destination x0 handshakes without writing
    lsu_valid_i = 1; lsu_waddr_i = 5'd0; lsu_wdata_i = 32'hFFFF_FFFF;
    cycle();
    check("t4_handshake", 32'(last_win), 32'd2);
    check("t4_no_write", 32'(wb_we_o), 32'd0);

`ifdef WB_SCOREBOARD_EN
    sb_set_i = 1; sb_set_addr_i = 5'd7;
    cycle(); check("t5_busy_set", 32'(busy_o[7]), 32'd1);
    cycle(); cycle();
    mdu_valid_i = 1; mdu_waddr_i = 5'd7; mdu_wdata_i = 32'h77;
    cycle(); check("t5_busy_during_write", 32'(busy_o[7]), 32'd1);
    cycle(); check("t5_busy_cleared", 32'(busy_o[7]), 32'd0);
    sb_set_i = 1; sb_set_addr_i = 5'd7;
    cycle();
    mdu_valid_i = 1; mdu_waddr_i = 5'd7; mdu_wdata_i = 32'h78;
    cycle();
    sb_set_i = 1; sb_set_addr_i = 5'd7;
    cycle(); check("t5_set_wins", 32'(busy_o[7]), 32'd1);
`else
    sb_set_i = 1; sb_set_addr_i = 5'd7;
    cycle(); check("t5_busy_zero", busy_o, 32'd0);
`endif

    // Async reset with a write on the port and sources still holding
    alu_valid_i = 1; alu_waddr_i = 5'd20; alu_wdata_i = 32'hCAFE;
    lsu_valid_i = 1; lsu_waddr_i = 5'd21; lsu_wdata_i = 32'hD1;
    mdu_valid_i = 1; mdu_waddr_i = 5'd22; mdu_wdata_i = 32'hD2;
    cycle();
    #2 rst = 1'b1;
    #1;
    check("t6_we", 32'(wb_we_o), 32'd0);
    check("t6_waddr", 32'(wb_waddr_o), 32'd0);
    check("t6_wdata", wb_wdata_o, 32'd0);
    check("t6_busy", busy_o, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check("t6_no_write_after_release", 32'(wb_we_o), 32'd0);
    for (int k = 0; k < 3; k++) cycle();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(2) == 0) begin
        alu_valid_i = 1; alu_waddr_i = reg_addr_t'($urandom); alu_wdata_i = $urandom;
      end
      if (!lsu_valid_i && $urandom_range(1) == 1) begin
        lsu_valid_i = 1; lsu_waddr_i = reg_addr_t'($urandom); lsu_wdata_i = $urandom;
      end
      if (!mdu_valid_i && $urandom_range(2) != 0) begin
        mdu_valid_i = 1; mdu_waddr_i = reg_addr_t'($urandom); mdu_wdata_i = $urandom;
      end
      if ($urandom_range(3) == 0) begin
        sb_set_i = 1; sb_set_addr_i = reg_addr_t'($urandom);
      end
      cycle();
    end
    for (int k = 0; k < 4; k++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
